// File: rtl/strobe_mon_pkg.sv
// Shared types and helpers for the strobe period monitor.
package strobe_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  // Inclusive window [expected - tol, expected + tol], written to avoid unsigned underflow.
  function automatic logic in_window(input int unsigned period,
                                     input int unsigned expected,
                                     input int unsigned tol);
    return ((period + tol) >= expected) && (period <= (expected + tol));
  endfunction

endpackage

// File: rtl/strobe_period_counter.sv
// Strobe rising-edge detect plus saturating cycle counter; flags period and timeout per event.
module strobe_period_counter #(
  parameter int unsigned EXPECTED_PERIOD = 241,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_strobe,
  output logic             o_event,
  output logic [CNT_W-1:0] o_period,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(EXPECTED_PERIOD + TOLERANCE - 1);

  logic             strobe_q;
  logic [CNT_W-1:0] cnt;

  assign o_event   = i_strobe & ~strobe_q;
  // Hold the period at full scale rather than wrapping to zero once saturated.
  assign o_period  = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign o_timeout = ~o_event & (cnt == TIMEOUT_AT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      strobe_q <= 1'b0;
      cnt      <= '0;
    end else begin
      strobe_q <= i_strobe;
      if (o_event) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/strobe_monitor.sv
// Strobe period monitor: measures strobe spacing, locks after consecutive good periods.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no reference edge yet; first event starts acquisition
//   ACQUIRE | counting consecutive in-tolerance periods toward lock
//   LOCKED  | strobe stable; bad period drops to ACQUIRE, timeout to IDLE
module strobe_monitor
  import strobe_mon_pkg::*;
#(
  parameter  int unsigned EXPECTED_PERIOD = 241,
  parameter  int unsigned TOLERANCE       = 2,
  parameter  int unsigned LOCK_COUNT      = 4,
  localparam int unsigned CNT_W           = $clog2(EXPECTED_PERIOD + TOLERANCE + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_strobe,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_error,
  output logic             o_miss
);

  if (TOLERANCE >= EXPECTED_PERIOD || LOCK_COUNT < 1) begin : g_bad_params
    $error("strobe_monitor: TOLERANCE must be below EXPECTED_PERIOD and LOCK_COUNT at least 1");
  end

  localparam int unsigned         GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0]   LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic             evt;
  logic             timeout;
  logic [CNT_W-1:0] evt_period;
  logic             in_tol;
  mon_state_e       state;
  logic [GOOD_W-1:0] good_cnt;

  strobe_period_counter #(
    .EXPECTED_PERIOD (EXPECTED_PERIOD),
    .TOLERANCE       (TOLERANCE),
    .CNT_W           (CNT_W)
  ) u_counter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_strobe  (i_strobe),
    .o_event   (evt),
    .o_period  (evt_period),
    .o_timeout (timeout)
  );

  assign in_tol = in_window(32'(evt_period), EXPECTED_PERIOD, TOLERANCE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      good_cnt       <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
      o_error        <= 1'b0;
      o_miss         <= 1'b0;
    end else begin
      o_period_valid <= 1'b0;
      o_error        <= 1'b0;
      o_miss         <= 1'b0;
      case (state)
        IDLE: begin
          if (evt) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (evt) begin
            o_period       <= evt_period;
            o_period_valid <= 1'b1;
            if (in_tol) begin
              if (good_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                o_locked <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              o_error  <= 1'b1;
              good_cnt <= '0;
            end
          end else if (timeout) begin
            state    <= IDLE;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (evt) begin
            o_period       <= evt_period;
            o_period_valid <= 1'b1;
            if (!in_tol) begin
              state    <= ACQUIRE;
              o_locked <= 1'b0;
              o_error  <= 1'b1;
              good_cnt <= '0;
            end
          end else if (timeout) begin
            state    <= IDLE;
            o_locked <= 1'b0;
            o_miss   <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          o_locked <= 1'b0;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule
